// File: rtl/input_pkg.sv
// rtl/input_pkg.sv - shared button indices, direction codes and default timing for the player input hub
package input_pkg;

    // Button positions within one player's group
    localparam int BTN_UP       = 0;
    localparam int BTN_DOWN     = 1;
    localparam int BTN_LEFT     = 2;
    localparam int BTN_RIGHT    = 3;
    localparam int BTN_FIRE     = 4;
    localparam int NUM_DIR_BTNS = 4;

    // Default timing at 25 MHz: 10 ms debounce, 500 ms first repeat, 100 ms repeat period
    localparam int DEF_DB_CYCLES  = 250000;
    localparam int DEF_RPT_DELAY  = 12500000;
    localparam int DEF_RPT_PERIOD = 2500000;

    typedef enum logic [2:0] {
        DIR_UP    = 3'd0,
        DIR_DOWN  = 3'd1,
        DIR_LEFT  = 3'd2,
        DIR_RIGHT = 3'd3,
        DIR_NONE  = 3'd4
    } dir_e;

    // Lowest-index direction set in a mask, NONE when the mask is empty
    function automatic dir_e lowest_dir(input logic [3:0] mask);
        if (mask[0]) return DIR_UP;
        if (mask[1]) return DIR_DOWN;
        if (mask[2]) return DIR_LEFT;
        if (mask[3]) return DIR_RIGHT;
        return DIR_NONE;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-button synchronizer, debounce counter and auto-repeat pulse generator
module btn_debounce #(
    parameter int DB_CYCLES  = 250000,
    parameter int RPT_DELAY  = 12500000,
    parameter int RPT_PERIOD = 2500000,
    parameter bit REPEAT_EN  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int DW     = $clog2(DB_CYCLES + 1);
    localparam int RPT_MX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RW     = $clog2(RPT_MX + 1);

    localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);
    localparam logic [RW-1:0] RPT_DLY_M1 = RW'(RPT_DELAY - 1);
    localparam logic [RW-1:0] RPT_PER_M1 = RW'(RPT_PERIOD - 1);

    logic          sync1_q, sync2_q;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic [RW-1:0] rpt_q, rpt_d;
    logic          press_q, press_d;

    // Debounce: count consecutive synced samples that disagree with the level
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == DB_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Press pulse on the rising level, then count down to each auto-repeat while held
    always_comb begin
        press_d = 1'b0;
        rpt_d   = '0;
        if (level_d && !level_q) begin
            press_d = 1'b1;
            rpt_d   = RPT_DLY_M1;
        end else if (level_d && level_q && REPEAT_EN) begin
            if (rpt_q == '0) begin
                press_d = 1'b1;
                rpt_d   = RPT_PER_M1;
            end else begin
                rpt_d = rpt_q - 1'b1;
            end
        end
    end

    // State registers including the two-flop synchronizer
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rpt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rpt_q   <= rpt_d;
            press_q <= press_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/player_input_hub.sv
// rtl/player_input_hub.sv - multi-player button hub: debounce, repeat, sticky presses and direction resolution
module player_input_hub #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_BTNS    = 5,
    parameter int DB_CYCLES   = input_pkg::DEF_DB_CYCLES,
    parameter int RPT_DELAY   = input_pkg::DEF_RPT_DELAY,
    parameter int RPT_PERIOD  = input_pkg::DEF_RPT_PERIOD
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PLAYERS*NUM_BTNS-1:0] i_btn,
    input  logic                            i_frame,
    output logic [NUM_PLAYERS*NUM_BTNS-1:0] o_level,
    output logic [NUM_PLAYERS*NUM_BTNS-1:0] o_press,
    output logic [NUM_PLAYERS*NUM_BTNS-1:0] o_latched,
    output logic [NUM_PLAYERS*3-1:0]        o_dir,
    output logic [NUM_PLAYERS*NUM_BTNS-1:0] o_led
);

    import input_pkg::*;

    localparam int NB = NUM_PLAYERS * NUM_BTNS;

    logic [NB-1:0] level, press;
    logic [NB-1:0] latched_q, latched_d;

    for (genvar g = 0; g < NB; g++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES  (DB_CYCLES),
            .RPT_DELAY  (RPT_DELAY),
            .RPT_PERIOD (RPT_PERIOD),
            .REPEAT_EN  ((g % NUM_BTNS) != BTN_FIRE)
        ) u_btn (
            .clk     (clk),
            .rst     (rst),
            .btn_i   (i_btn[g]),
            .level_o (level[g]),
            .press_o (press[g])
        );
    end

    // Sticky press flags: a new press outranks a simultaneous frame clear
    always_comb begin
        latched_d = press | (latched_q & ~{NB{i_frame}});
    end

    // Latched flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            latched_q <= '0;
        end else begin
            latched_q <= latched_d;
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [NUM_DIR_BTNS-1:0] held, rise, prev_q;
        logic [2:0]              dir_q, dir_d;

        assign held = level[p*NUM_BTNS +: NUM_DIR_BTNS];
        assign rise = held & ~prev_q;

        // Newest press wins (lowest index on ties); on release of the current one fall back to lowest held
        always_comb begin
            dir_d = dir_q;
            if (|rise) begin
                dir_d = lowest_dir(rise);
            end else if (dir_q != DIR_NONE && !held[dir_q[1:0]]) begin
                dir_d = lowest_dir(held);
            end
        end

        // Direction and previous-level registers
        always_ff @(posedge clk) begin
            if (rst) begin
                prev_q <= '0;
                dir_q  <= DIR_NONE;
            end else begin
                prev_q <= held;
                dir_q  <= dir_d;
            end
        end

        assign o_dir[p*3 +: 3] = dir_q;
    end

    assign o_level   = level;
    assign o_led     = level;
    assign o_press   = press;
    assign o_latched = latched_q;

endmodule

// File: tb/tb_player_input_hub.sv
// tb/tb_player_input_hub.sv - self-checking bench for player_input_hub with a behavioural reference model
module tb_player_input_hub;

    localparam int NP  = 4;
    localparam int NBT = 5;
    localparam int NB  = NP * NBT;
    localparam int DB  = 4;
    localparam int RD  = 20;
    localparam int RP  = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_frame;
    logic [NB-1:0] i_btn;
    logic [NB-1:0] o_level, o_press, o_latched, o_led;
    logic [NP*3-1:0] o_dir;

    always #5 clk = ~clk;

    player_input_hub #(
        .NUM_PLAYERS (NP),
        .NUM_BTNS    (NBT),
        .DB_CYCLES   (DB),
        .RPT_DELAY   (RD),
        .RPT_PERIOD  (RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_btn     (i_btn),
        .i_frame   (i_frame),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_latched (o_latched),
        .o_dir     (o_dir),
        .o_led     (o_led)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_s1[NB], m_s2[NB], m_lvl[NB], m_prev[NB], m_press[NB], m_lat[NB];
    int m_run[NB], m_age[NB], m_dir[NP];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NB; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_prev[i] = 0;
                m_press[i] = 0; m_lat[i] = 0; m_run[i] = 0; m_age[i] = 0;
            end
            for (int p = 0; p < NP; p++) m_dir[p] = 4;
        end else begin
            for (int p = 0; p < NP; p++) begin
                int lo_rise, lo_held;
                lo_rise = 4;
                lo_held = 4;
                for (int d = 3; d >= 0; d--) begin
                    if (m_lvl[p*NBT+d] && !m_prev[p*NBT+d]) lo_rise = d;
                    if (m_lvl[p*NBT+d]) lo_held = d;
                end
                if (lo_rise != 4) m_dir[p] = lo_rise;
                else if (m_dir[p] != 4 && !m_lvl[p*NBT+m_dir[p]]) m_dir[p] = lo_held;
            end
            for (int i = 0; i < NB; i++) begin
                bit nl;
                m_lat[i] = m_press[i] | (m_lat[i] & !i_frame);
                m_prev[i] = m_lvl[i];
                nl = m_lvl[i];
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        nl = !nl;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (nl && !m_lvl[i]) begin
                    m_age[i] = 0;
                    m_press[i] = 1;
                end else if (nl && m_lvl[i]) begin
                    m_age[i]++;
                    m_press[i] = (i % NBT != 4) && m_age[i] >= RD && ((m_age[i] - RD) % RP == 0);
                end else begin
                    m_age[i] = 0;
                    m_press[i] = 0;
                end
                m_lvl[i] = nl;
                m_s2[i] = m_s1[i];
                m_s1[i] = i_btn[i];
            end
        end
    end

    logic [NB-1:0]   e_lvl, e_prs, e_lat;
    logic [NP*3-1:0] e_dir;

    always @(negedge clk) begin
        for (int i = 0; i < NB; i++) begin
            e_lvl[i] = m_lvl[i];
            e_prs[i] = m_press[i];
            e_lat[i] = m_lat[i];
        end
        for (int p = 0; p < NP; p++) e_dir[p*3 +: 3] = 3'(m_dir[p]);
        check("model_level", 32'(o_level), 32'(e_lvl));
        check("model_press", 32'(o_press), 32'(e_prs));
        check("model_latched", 32'(o_latched), 32'(e_lat));
        check("model_dir", 32'(o_dir), 32'(e_dir));
        check("model_led", 32'(o_led), 32'(e_lvl));
    end

    // ---------------- directed helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_clear();
        i_frame = 1'b1;
        step(1);
        i_frame = 1'b0;
        step(1);
    endtask

    task automatic wait_press(input int idx);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!o_press[idx] && w < 20);
        check("press_seen", 32'(o_press[idx]), 32'd1);
    endtask

    task automatic repeat_run(input int idx, input int n);
        logic exp;
        i_btn[idx] = 1'b1;
        wait_press(idx);
        for (int off = 1; off < n; off++) begin
            @(negedge clk);
            exp = (idx != 4) && (off == RD || (off > RD && (off - RD) % RP == 0));
            check("rpt_pulse", 32'(o_press[idx]), 32'(exp));
        end
        i_btn[idx] = 1'b0;
        step(10);
    endtask

    typedef struct {
        logic btn;
        logic lvl;
        logic prs;
        logic lat;
        int   dir;
    } vec_t;

    vec_t vec[10];

    initial begin
        for (int k = 0; k < 10; k++) begin
            vec[k].btn = (k != 1);
            vec[k].lvl = (k >= 7);
            vec[k].prs = (k == 7);
            vec[k].lat = (k >= 8);
            vec[k].dir = (k >= 8) ? 0 : 4;
        end

        rst = 1'b1;
        i_btn = '0;
        i_frame = 1'b0;
        step(3);
        check("rst_level", 32'(o_level), 32'd0);
        check("rst_press", 32'(o_press), 32'd0);
        check("rst_latched", 32'(o_latched), 32'd0);
        check("rst_led", 32'(o_led), 32'd0);
        check("rst_dir", 32'(o_dir), 32'h924);
        rst = 1'b0;
        step(5);

        // bounce on p0 up, then stable hold
        for (int k = 0; k < 10; k++) begin
            i_btn[0] = vec[k].btn;
            @(negedge clk);
            check("tbl_level", 32'(o_level[0]), 32'(vec[k].lvl));
            check("tbl_press", 32'(o_press[0]), 32'(vec[k].prs));
            check("tbl_latched", 32'(o_latched[0]), 32'(vec[k].lat));
            check("tbl_dir", 32'(o_dir[2:0]), 32'(vec[k].dir));
        end
        i_btn = '0;
        step(10);
        frame_clear();

        // auto-repeat, restart after release, and fire without repeat
        repeat_run(3, 60);
        repeat_run(3, 25);
        repeat_run(4, 61);

        // direction priority
        i_btn[0] = 1'b1; step(8);
        check("dir_up", 32'(o_dir[2:0]), 32'd0);
        i_btn[2] = 1'b1; step(8);
        check("dir_left", 32'(o_dir[2:0]), 32'd2);
        i_btn[2] = 1'b0; step(8);
        check("dir_back_up", 32'(o_dir[2:0]), 32'd0);
        i_btn[0] = 1'b0; step(8);
        check("dir_none", 32'(o_dir[2:0]), 32'd4);
        i_btn[1] = 1'b1; i_btn[3] = 1'b1; step(8);
        check("dir_simul", 32'(o_dir[2:0]), 32'd1);
        i_btn = '0;
        step(10);
        frame_clear();

        // latch held through frame, then cleared
        check("lat_clear", 32'(o_latched[4]), 32'd0);
        i_btn[4] = 1'b1;
        wait_press(4);
        step(1);
        check("lat_set", 32'(o_latched[4]), 32'd1);
        step(9);
        i_frame = 1'b1;
        check("lat_frame_cycle", 32'(o_latched[4]), 32'd1);
        step(1);
        i_frame = 1'b0;
        check("lat_after_frame", 32'(o_latched[4]), 32'd0);
        i_btn[4] = 1'b0;
        step(10);
        // frame coinciding with the press
        i_btn[4] = 1'b1;
        wait_press(4);
        i_frame = 1'b1;
        step(1);
        i_frame = 1'b0;
        check("lat_coincide", 32'(o_latched[4]), 32'd1);
        step(1);
        check("lat_coincide_hold", 32'(o_latched[4]), 32'd1);
        i_btn = '0;
        step(10);
        frame_clear();

        // reset mid-hold, then fresh debounce
        i_btn[0] = 1'b1;
        step(10);
        check("hold_level", 32'(o_level[0]), 32'd1);
        rst = 1'b1;
        step(1);
        check("midrst_level", 32'(o_level), 32'd0);
        check("midrst_latched", 32'(o_latched), 32'd0);
        check("midrst_dir", 32'(o_dir), 32'h924);
        step(2);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (i < 5) check("repress_wait", 32'(o_level[0]), 32'd0);
            else check("repress_pulse", 32'(o_press[0]), 32'd1);
        end
        i_btn = '0;
        step(10);
        frame_clear();

        // only player 2 active: others stay idle
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < NBT; b++)
                if ($urandom_range(11) == 0) i_btn[10+b] = ~i_btn[10+b];
            i_frame = ($urandom_range(19) == 0);
            step(1);
            check("iso_level", 32'(o_level & ~20'h07C00), 32'd0);
            check("iso_press", 32'(o_press & ~20'h07C00), 32'd0);
            check("iso_latched", 32'(o_latched & ~20'h07C00), 32'd0);
            check("iso_dir", 32'({o_dir[11:9], o_dir[5:0]}), 32'h124);
        end
        i_btn = '0;
        i_frame = 1'b0;
        step(10);

        // fully random traffic: bouncy phases, calm phases, occasional reset
        for (int c = 0; c < 3000; c++) begin
            int prob;
            prob = ((c / 300) % 2 == 0) ? 3 : 39;
            for (int i = 0; i < NB; i++)
                if ($urandom_range(prob) == 0) i_btn[i] = ~i_btn[i];
            i_frame = ($urandom_range(9) == 0);
            rst = ($urandom_range(499) == 0);
            step(1);
        end
        rst = 1'b0;
        i_frame = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/player_input_hub.md
PLAYER_INPUT_HUB -- requirements
Module: player_input_hub

Interface
REQ-001 The block SHALL take parameter NUM_PLAYERS, default 2, as the number of independent players.
REQ-002 The block SHALL take parameter NUM_BTNS, default 5, as the buttons per player; index 0 up, 1 down, 2 left, 3 right, 4 fire.
REQ-003 The block SHALL take parameter DB_CYCLES, default 250000, as the debounce window (10 ms at 25 MHz).
REQ-004 The block SHALL take parameter RPT_DELAY, default 12500000, as the cycles from press to first auto-repeat.
REQ-005 The block SHALL take parameter RPT_PERIOD, default 2500000, as the cycles between subsequent auto-repeats.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port i_btn, input, NUM_PLAYERS*NUM_BTNS bits: raw asynchronous buttons, active-high; bit p*NUM_BTNS+b is player p, button b.
REQ-009 The block SHALL have port i_frame, input, 1 bit: consumer strobe that clears latched presses.
REQ-010 The block SHALL have port o_level, output, NUM_PLAYERS*NUM_BTNS bits: debounced button level.
REQ-011 The block SHALL have port o_press, output, NUM_PLAYERS*NUM_BTNS bits: one-cycle press and auto-repeat pulses.
REQ-012 The block SHALL have port o_latched, output, NUM_PLAYERS*NUM_BTNS bits: sticky press flags, held until i_frame.
REQ-013 The block SHALL have port o_dir, output, NUM_PLAYERS*3 bits: resolved direction per player.
REQ-014 The block SHALL have port o_led, output, NUM_PLAYERS*NUM_BTNS bits: LED drive equal to o_level.

Function
REQ-015 Each i_btn bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-016 Each button SHALL have a debounce counter of width $clog2(DB_CYCLES+1): it increments while the synced value differs from o_level and clears when they match.
REQ-017 o_level SHALL toggle, and the counter clear, on the cycle after DB_CYCLES consecutive differing synced samples; any matching sample restarts the count.
REQ-018 o_press SHALL pulse for exactly one cycle on the cycle o_level goes 0 to 1.
REQ-019 While a direction button (indices 0-3) stays at level 1, o_press SHALL pulse again RPT_DELAY cycles after the initial pulse, then every RPT_PERIOD cycles.
REQ-020 The fire button (index 4) SHALL never auto-repeat.
REQ-021 A release SHALL clear that button's repeat counter immediately, and a following press SHALL restart from RPT_DELAY.
REQ-022 o_latched SHALL set on any o_press pulse and clear on the cycle after i_frame=1.
REQ-023 If o_press and i_frame coincide, o_latched SHALL remain 1 (the new press wins).
REQ-024 o_dir codes SHALL be: UP=0, DOWN=1, LEFT=2, RIGHT=3, NONE=4.
REQ-025 o_dir SHALL be the most recently pressed direction whose level is still 1.
REQ-026 If several direction presses occur in the same cycle, o_dir SHALL take the lowest index among them.
REQ-027 When the current o_dir button releases, o_dir SHALL fall back to the lowest-index direction still held, or NONE if none is held, on the next cycle.
REQ-028 o_dir SHALL update one cycle after the o_level change that causes it.
REQ-029 Players SHALL be fully independent: no event on player p SHALL affect player q's outputs.

Reset
REQ-030 While rst=1, the synchronizers, counters, o_level, o_press, o_latched and o_led SHALL be 0 and o_dir SHALL be NONE.
REQ-031 A button still held when rst deasserts SHALL be debounced afresh and SHALL produce a press only after 2+DB_CYCLES cycles.

Structure
REQ-032 Button index constants, the o_dir code enum and the default timing constants SHALL live in the shared package input_pkg.
REQ-033 Synchronizer, debounce and repeat logic SHALL be the sub-module btn_debounce, instantiated NUM_PLAYERS*NUM_BTNS times; direction resolution and latching SHALL stay in player_input_hub.

Verification (all scenarios run with DB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=5)
REQ-034 Bounce: toggle p0 up every cycle for 3 cycles, then hold 1 -> o_level[0] stays 0 during the bounce, rises 6 cycles after the stable edge, and o_press[0] pulses once.
REQ-035 Repeat: hold p0 right for 60 cycles after the first pulse at t0 -> o_press[3] pulses at t0, t0+20, t0+25 ... t0+55; holding fire for 60 cycles -> exactly one pulse.
REQ-036 Direction: hold up, then hold left, release left, release up -> o_dir sequence UP, LEFT, UP, NONE.
REQ-037 Simultaneous: press down and right in the same cycle -> o_dir=DOWN.
REQ-038 Latch: press fire, then i_frame 10 cycles later -> o_latched[4] is 1 through the frame cycle and 0 after; i_frame on the press cycle -> o_latched stays 1.
REQ-039 Reset and scaling: assert rst mid-hold -> all outputs clear and the re-press appears 6 cycles after release; with NUM_PLAYERS=4, stimulus on p2 only -> p0, p1 and p3 outputs stay at their idle values.
